// File: rtl/note_sequencer.sv
// note_sequencer
//   Plays a melody by stepping through an external synchronous song memory.
//   Each 16-bit entry holds a duration in ticks ([15:12]) and a 12-bit period
//   value ([11:0]). The period value and a gate are driven to the downstream
//   synth stage. A duration of 0 marks the end of the song.
//
// Ports
//   clk        system clock
//   rst_n      asynchronous reset, active-low
//   start      level-sampled; begins playback from address 0 when idle
//   stop       level-sampled; aborts playback from any state
//   loop_en    sampled at end-of-song; 1 restarts at address 0
//   song_addr  registered address to song memory
//   song_data  memory entry, valid one clock after song_addr
//   value      period value to downstream; holds last loaded note
//   note_on    registered gate; low means mute
//   busy       high in FETCH, LOAD, PLAY and GAP
//   done       one-clock pulse when the song ends naturally
module note_sequencer #(
  parameter int TICK_DIV   = 6250000,
  parameter int GAP_CYCLES = 500000,
  parameter int ADDR_W     = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic              loop_en,
  output logic [ADDR_W-1:0] song_addr,
  input  logic [15:0]       song_data,
  output logic [11:0]       value,
  output logic              note_on,
  output logic              busy,
  output logic              done
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_PLAY  = 3'd3;
  localparam logic [2:0] S_GAP   = 3'd4;

  localparam int TICK_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int GAP_W     = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int GAP_LAST_I = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_LAST_I);

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [11:0]       value_q, value_d;
  logic              note_on_q, note_on_d;
  logic              done_q, done_d;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic [3:0]        dur_q, dur_d;
  logic [GAP_W-1:0]  gap_q, gap_d;

  // Request flags raised by the state logic and resolved after the case:
  // adv moves to the next entry, eos handles the end of the song.
  logic adv;
  logic eos;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    value_d   = value_q;
    note_on_d = note_on_q;
    done_d    = 1'b0;
    tick_d    = tick_q;
    dur_d     = dur_q;
    gap_d     = gap_q;
    adv       = 1'b0;
    eos       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FETCH;
          addr_d  = '0;
        end
      end

      // Address is already on song_addr; memory returns data next clock.
      S_FETCH: state_d = S_LOAD;

      S_LOAD: begin
        if (song_data[15:12] == 4'd0) begin
          eos = 1'b1;
        end else begin
          value_d   = song_data[11:0];
          dur_d     = song_data[15:12];
          tick_d    = '0;
          // A zero period is a rest: stay muted for the whole duration.
          note_on_d = (song_data[11:0] != 12'd0);
          state_d   = S_PLAY;
        end
      end

      S_PLAY: begin
        if (tick_q == TICK_LAST) begin
          tick_d = '0;
          if (dur_q == 4'd1) begin
            note_on_d = 1'b0;
            dur_d     = 4'd0;
            if (GAP_CYCLES == 0) begin
              adv = 1'b1;
            end else begin
              state_d = S_GAP;
              gap_d   = '0;
            end
          end else begin
            dur_d = dur_q - 4'd1;
          end
        end else begin
          tick_d = tick_q + TICK_W'(1);
        end
      end

      S_GAP: begin
        if (gap_q == GAP_LAST) begin
          gap_d = '0;
          adv   = 1'b1;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase

    // The last address has no successor, so it ends the song instead of
    // wrapping the counter.
    if (adv) begin
      if (addr_q == '1) begin
        eos = 1'b1;
      end else begin
        addr_d  = addr_q + ADDR_W'(1);
        state_d = S_FETCH;
      end
    end

    // A marker at address 0 means an empty song; never loop on it.
    if (eos) begin
      addr_d = '0;
      if (loop_en && (addr_q != '0)) begin
        state_d = S_FETCH;
      end else begin
        state_d = S_IDLE;
        done_d  = 1'b1;
      end
    end

    // stop overrides everything, including a simultaneous start; value is
    // deliberately left holding the last note.
    if (stop) begin
      state_d   = S_IDLE;
      addr_d    = '0;
      note_on_d = 1'b0;
      done_d    = 1'b0;
      tick_d    = '0;
      dur_d     = 4'd0;
      gap_d     = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      value_q   <= 12'd0;
      note_on_q <= 1'b0;
      done_q    <= 1'b0;
      tick_q    <= '0;
      dur_q     <= 4'd0;
      gap_q     <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      value_q   <= value_d;
      note_on_q <= note_on_d;
      done_q    <= done_d;
      tick_q    <= tick_d;
      dur_q     <= dur_d;
      gap_q     <= gap_d;
    end
  end

  assign song_addr = addr_q;
  assign value     = value_q;
  assign note_on   = note_on_q;
  assign done      = done_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_note_sequencer.sv
// Testbench for note_sequencer. Stimulus pushes the expected run-length
// segments of {note_on, value, song_addr} seen while busy, followed by an
// end record; a monitor process rebuilds the segments from the DUT and
// compares them against the queue.
module tb_note_sequencer;

  localparam int TICK_DIV   = 4;
  localparam int GAP_CYCLES = 2;
  localparam int ADDR_W     = 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              stop = 1'b0;
  logic              loop_en = 1'b0;
  logic [ADDR_W-1:0] song_addr;
  logic [15:0]       song_data;
  logic [11:0]       value;
  logic              note_on;
  logic              busy;
  logic              done;

  logic [15:0] mem [8];

  int checks = 0;
  int errors = 0;
  int done_seen = 0;
  int seg_idx = 0;

  typedef struct {
    bit          is_end;
    logic        on;
    logic [11:0] val;
    logic [2:0]  addr;
    int          len;
    logic        dn;
  } exp_t;

  exp_t q[$];

  bit          mon_act = 1'b0;
  logic [15:0] mon_key = '0;
  int          mon_len = 0;

  note_sequencer #(
    .TICK_DIV  (TICK_DIV),
    .GAP_CYCLES(GAP_CYCLES),
    .ADDR_W    (ADDR_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .stop     (stop),
    .loop_en  (loop_en),
    .song_addr(song_addr),
    .song_data(song_data),
    .value    (value),
    .note_on  (note_on),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  // Synchronous song memory: data valid one clock after the address.
  always @(posedge clk) song_data <= mem[song_addr];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  function automatic void push_seg(input logic on, input logic [11:0] v,
                                   input logic [2:0] a, input int len);
    exp_t e;
    e.is_end = 1'b0;
    e.on     = on;
    e.val    = v;
    e.addr   = a;
    e.len    = len;
    e.dn     = 1'b0;
    q.push_back(e);
  endfunction

  function automatic void push_end(input logic d);
    exp_t e;
    e.is_end = 1'b1;
    e.on     = 1'b0;
    e.val    = 12'd0;
    e.addr   = 3'd0;
    e.len    = 0;
    e.dn     = d;
    q.push_back(e);
  endfunction

  task automatic close_seg(input logic [15:0] k, input int n);
    exp_t e;
    seg_idx++;
    if (q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL seg%0d_unexpected: got on=%0b val=%h addr=%0d len=%0d, want nothing",
               seg_idx, k[15], k[14:3], k[2:0], n);
    end else begin
      e = q.pop_front();
      if (e.is_end) begin
        checks++;
        errors++;
        $display("FAIL seg%0d_order: got segment on=%0b val=%h addr=%0d len=%0d, want end of playback",
                 seg_idx, k[15], k[14:3], k[2:0], n);
      end else begin
        chk($sformatf("seg%0d_note_on", seg_idx), {31'd0, k[15]}, {31'd0, e.on});
        chk($sformatf("seg%0d_value", seg_idx), {20'd0, k[14:3]}, {20'd0, e.val});
        chk($sformatf("seg%0d_addr", seg_idx), {29'd0, k[2:0]}, {29'd0, e.addr});
        chk($sformatf("seg%0d_len", seg_idx), n, e.len);
      end
    end
  endtask

  task automatic close_end();
    exp_t e;
    seg_idx++;
    if (q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL end%0d_unexpected: got end of playback done=%0b, want nothing", seg_idx, done);
    end else begin
      e = q.pop_front();
      if (!e.is_end) begin
        checks++;
        errors++;
        $display("FAIL end%0d_order: got end of playback, want segment on=%0b val=%h addr=%0d len=%0d",
                 seg_idx, e.on, e.val, e.addr, e.len);
      end else begin
        chk($sformatf("end%0d_done", seg_idx), {31'd0, done}, {31'd0, e.dn});
        chk($sformatf("end%0d_note_on", seg_idx), {31'd0, note_on}, 32'd0);
        chk($sformatf("end%0d_addr", seg_idx), {29'd0, song_addr}, 32'd0);
      end
    end
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (done === 1'b1) done_seen++;
      if (busy === 1'b1) begin
        if (mon_act && ({note_on, value, song_addr} == mon_key)) begin
          mon_len++;
        end else begin
          if (mon_act) close_seg(mon_key, mon_len);
          mon_act = 1'b1;
          mon_key = {note_on, value, song_addr};
          mon_len = 1;
        end
      end else if (mon_act) begin
        close_seg(mon_key, mon_len);
        mon_act = 1'b0;
        close_end();
      end
    end
  end

  // start is sampled on the second posedge of this task (edge k); the task
  // returns 1 time unit after edge k.
  task automatic do_start();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_drain(input int budget, input string name);
    int n = 0;
    while (((q.size() != 0) || (busy !== 1'b0)) && (n < budget)) begin
      @(posedge clk);
      n++;
    end
    #1;
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL %s_timeout: got %0d pending records busy=%0b, want 0 pending and idle",
               name, q.size(), busy);
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got simulation still running, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 8; i++) mem[i] = 16'h0000;

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_song_addr", {29'd0, song_addr}, 32'd0);
    chk("rst_value", {20'd0, value}, 32'd0);
    chk("rst_note_on", {31'd0, note_on}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1 chk("post_rst_busy", {31'd0, busy}, 32'd0);

    // Two notes then an end marker
    mem[0] = 16'h2100; mem[1] = 16'h1080; mem[2] = 16'h0000;
    loop_en = 1'b0;
    push_seg(1'b0, 12'h000, 3'd0, 2);
    push_seg(1'b1, 12'h100, 3'd0, 8);
    push_seg(1'b0, 12'h100, 3'd0, 2);
    push_seg(1'b0, 12'h100, 3'd1, 2);
    push_seg(1'b1, 12'h080, 3'd1, 4);
    push_seg(1'b0, 12'h080, 3'd1, 2);
    push_seg(1'b0, 12'h080, 3'd2, 2);
    push_end(1'b1);
    do_start();
    wait_drain(300, "t1");

    // Rest entry: muted for 12 clocks of PLAY plus the gap
    mem[0] = 16'h3000; mem[1] = 16'h0000;
    push_seg(1'b0, 12'h080, 3'd0, 2);
    push_seg(1'b0, 12'h000, 3'd0, 14);
    push_seg(1'b0, 12'h000, 3'd1, 2);
    push_end(1'b1);
    do_start();
    wait_drain(300, "t2");

    // Full song without loop: ends after address 7
    for (int i = 0; i < 8; i++) mem[i] = 16'h1010;
    loop_en = 1'b0;
    push_seg(1'b0, 12'h000, 3'd0, 2);
    for (int n = 0; n < 8; n++) begin
      push_seg(1'b1, 12'h010, 3'(n), 4);
      push_seg(1'b0, 12'h010, 3'(n), 2);
      if (n < 7) push_seg(1'b0, 12'h010, 3'(n + 1), 2);
    end
    push_end(1'b1);
    do_start();
    wait_drain(300, "t3a");

    // Full song with loop: wraps 7 -> 0, stopped 2 clocks into the repeat
    loop_en = 1'b1;
    push_seg(1'b0, 12'h010, 3'd0, 2);
    for (int n = 0; n < 8; n++) begin
      push_seg(1'b1, 12'h010, 3'(n), 4);
      push_seg(1'b0, 12'h010, 3'(n), 2);
      push_seg(1'b0, 12'h010, 3'((n + 1) % 8), 2);
    end
    push_seg(1'b1, 12'h010, 3'd0, 2);
    push_end(1'b0);
    do_start();
    repeat (67) @(posedge clk);
    #1 stop = 1'b1;
    @(posedge clk);
    #1 stop = 1'b0;
    chk("stop_busy", {31'd0, busy}, 32'd0);
    chk("stop_note_on", {31'd0, note_on}, 32'd0);
    chk("stop_addr", {29'd0, song_addr}, 32'd0);
    chk("stop_value_held", {20'd0, value}, 32'h010);
    wait_drain(300, "t3b");

    // start and stop together while idle
    @(posedge clk);
    #1 begin start = 1'b1; stop = 1'b1; end
    @(posedge clk);
    #1 begin start = 1'b0; stop = 1'b0; end
    repeat (5) @(posedge clk);
    #1 chk("start_stop_busy", {31'd0, busy}, 32'd0);

    // Empty song with loop enabled: no repeat fetch
    for (int i = 0; i < 8; i++) mem[i] = 16'h0000;
    loop_en = 1'b1;
    push_seg(1'b0, 12'h010, 3'd0, 2);
    push_end(1'b1);
    do_start();
    wait_drain(50, "t4");
    repeat (10) @(posedge clk);
    #1 chk("empty_no_refetch_busy", {31'd0, busy}, 32'd0);

    // Asynchronous reset mid-PLAY
    mem[0] = 16'h2100; mem[1] = 16'h0000;
    loop_en = 1'b0;
    push_seg(1'b0, 12'h010, 3'd0, 2);
    push_seg(1'b1, 12'h100, 3'd0, 2);
    push_end(1'b0);
    do_start();
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_note_on", {31'd0, note_on}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_value", {20'd0, value}, 32'd0);
    chk("arst_addr", {29'd0, song_addr}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("arst_release_busy", {31'd0, busy}, 32'd0);
    chk("arst_release_note_on", {31'd0, note_on}, 32'd0);

    // Playback works again after reset; value restarts from 0
    mem[0] = 16'h1080; mem[1] = 16'h0000;
    push_seg(1'b0, 12'h000, 3'd0, 2);
    push_seg(1'b1, 12'h080, 3'd0, 4);
    push_seg(1'b0, 12'h080, 3'd0, 2);
    push_seg(1'b0, 12'h080, 3'd1, 2);
    push_end(1'b1);
    do_start();
    wait_drain(100, "t6b");

    chk("done_pulse_count", done_seen, 5);
    chk("queue_empty", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/note_sequencer.md
Name: note_sequencer

Overview:
Plays a melody by stepping through an external synchronous song memory of note entries. Drives the 12-bit period `value` and a gate into the synth_controller / sine-ROM stage directly downstream. Provides start/stop/loop control, with a short articulation gap between notes. Note duration is counted in ticks, and TICK_DIV clocks make one tick.

Parameters:
TICK_DIV, 6250000, clocks per duration tick (1/16 s at 100 MHz); must be >= 1
GAP_CYCLES, 500000, clocks of silence after each note; 0 means no gap state
ADDR_W, 6, song memory address width; song length is 2**ADDR_W entries

Ports:
clk  input  1  system clock, 100 MHz
rst_n  input  1  asynchronous reset, active-low
start  input  1  level-sampled; begins playback from address 0 when idle
stop  input  1  level-sampled; aborts playback from any state
loop_en  input  1  sampled at end-of-song; 1 = restart at address 0
song_addr  output  ADDR_W  registered address to song memory
song_data  input  16  entry at song_addr, valid 1 clock after song_addr; [15:12] duration ticks, [11:0] period value
value  output  12  period value to synth_controller; holds last loaded note
note_on  output  1  gate to the audio path; low means mute
busy  output  1  high in FETCH, LOAD, PLAY, GAP
done  output  1  1-clock pulse when the song ends naturally

Behaviour:
- Reset (rst_n low, async): state IDLE; song_addr, value, note_on, busy, done, tick and duration counters all 0.
- States: IDLE, FETCH, LOAD, PLAY, GAP.
- IDLE: on start=1 and stop=0, go to FETCH with song_addr=0. start is ignored in all other states.
- FETCH: 1 clock; the address is presented to the song memory. Go to LOAD.
- LOAD: 1 clock; capture song_data. The entry's duration field is dur.
  - If dur==0 (end marker): end of song.
  - Otherwise: value <= data[11:0]; dur_cnt <= dur; tick_cnt <= 0; go to PLAY.
- PLAY: note_on = (value != 0). Value 0 is a rest, so downstream is muted.
  - tick_cnt counts 0..TICK_DIV-1 and wraps.
  - On each wrap, dur_cnt decrements.
  - When dur_cnt==1 and tick_cnt wraps, leave PLAY.
  - PLAY therefore lasts exactly dur*TICK_DIV clocks.
- GAP: note_on=0 for GAP_CYCLES clocks. When GAP_CYCLES==0, PLAY advances directly.
- Advance: if song_addr == 2**ADDR_W-1, end of song. Otherwise song_addr+1, then FETCH.
- End of song:
  - If loop_en=1 and song_addr!=0: song_addr <= 0, FETCH. There is no done pulse.
  - Otherwise: IDLE, done=1 for one clock, song_addr <= 0.
  - An end marker at address 0 always goes to IDLE with done. This prevents an empty song from looping forever.
- Latency: start sampled at edge k gives FETCH after k, LOAD after k+1, and PLAY (value valid, note_on high) after edge k+2.
- stop=1 at any edge: next state IDLE, note_on=0, busy=0, song_addr=0, counters cleared, no done pulse. value holds its last value.
  - stop beats start when both are sampled high on the same edge.
- note_on is a registered output: it changes only on state transitions and never glitches mid-note.
- value changes only in LOAD, so downstream never sees a value change while note_on is high except at note boundaries.
- Width rules: tick_cnt is wide enough for TICK_DIV-1; dur_cnt is 4 bits. There are no arithmetic overflows: song_addr wrap is handled explicitly above.
- Asynchronous reset mid-note: outputs go to their reset values immediately. Playback does not resume on release.

Test Plan:
(bench uses TICK_DIV=4, GAP_CYCLES=2, ADDR_W=3)
1. Memory {0x2100, 0x1080, 0x0000}; start pulse at edge k -> value=0x100 and note_on=1 after edge k+2 for 8 clocks; note_on=0 for 2 clocks; value=0x080 with note_on=1 for 4 clocks; done pulses once; busy=0; song_addr=0.
2. Entry 0x3000 (rest) -> note_on stays 0 for 12 clocks while busy=1; value=0x000.
3. All 8 entries 0x1010, loop_en=0 -> song_addr 0..7, then IDLE with done. With loop_en=1 -> song_addr wraps 7->0 and playback continues, no done.
4. Memory {0x0000}, loop_en=1, start -> IDLE with done after LOAD (3 clocks); no repeat fetch.
5. stop asserted mid-PLAY -> next edge note_on=0, busy=0, song_addr=0, no done. start and stop high together in IDLE -> stays IDLE.
6. rst_n pulled low mid-PLAY -> note_on, busy, value, song_addr all 0 immediately. After release, stays IDLE until start.
